// File: rtl/mseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mseq_pkg
//  Description : Shared definitions for the m-sequence decoder slice.
//                Holds the sequence degree/length, the seed window, the
//                feedback taps, the decoder state encoding and the
//                next-bit prediction function.
//  Revision    : 1.0 - initial release
// ============================================================================
package mseq_pkg;

  // Degree of the generating polynomial and resulting sequence length.
  localparam int DEG = 5;
  localparam int LEN = 31;

  // Window holding a_0..a_4 (a_0 in the MSB).
  localparam logic [DEG-1:0] SEED = 5'b00001;

  // a_(k+5) = a_(k+3) ^ a_k. With W[4]=a_k, a_(k+3) sits in W[1].
  localparam int TAP_HI = 4;
  localparam int TAP_LO = 1;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } mseq_state_e;

  // Predicted next sequence bit for a given window.
  function automatic logic mseq_next(input logic [DEG-1:0] win);
    return win[TAP_HI] ^ win[TAP_LO];
  endfunction

endpackage : mseq_pkg
`default_nettype wire

// File: rtl/mseq_pos_lut.sv
`default_nettype none
// ============================================================================
//  Module      : mseq_pos_lut
//  Description : Combinational window-to-position ROM. Entries are built at
//                elaboration by stepping the recurrence from the seed; the
//                position returned is that of the newest (LSB) window bit.
//                The all-zero window never occurs in the sequence: it maps
//                to position 0 and is flagged invalid.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    window_i  in  DEG  received window, newest bit in LSB
//    pos_o     out 8    index 0..LEN-1 of the newest bit
//    valid_o   out 1    window is a legal (nonzero) sequence window
// ============================================================================
module mseq_pos_lut #(
  parameter int DEG = 5,
  parameter int LEN = 31
) (
  input  logic [DEG-1:0] window_i,
  output logic [7:0]     pos_o,
  output logic           valid_o
);
  import mseq_pkg::*;

  // Window that starts at sequence index k (a_k in the MSB).
  function automatic logic [DEG-1:0] win_at(input int k);
    logic [DEG-1:0] w;
    w = SEED;
    for (int i = 0; i < k; i++) begin
      w = {w[DEG-2:0], mseq_next(w)};
    end
    return w;
  endfunction

  logic [LEN-1:0] hit;

  for (genvar k = 0; k < LEN; k++) begin : g_rom
    localparam logic [DEG-1:0] c_WIN = win_at(k);
    assign hit[k] = (window_i == c_WIN);
  end

  // Every nonzero window appears exactly once, so at most one hit is set.
  always_comb begin
    pos_o = '0;
    for (int k = 0; k < LEN; k++) begin
      if (hit[k]) pos_o = 8'((k + DEG - 1) % LEN);
    end
  end

  assign valid_o = |window_i;

endmodule : mseq_pos_lut
`default_nettype wire

// File: rtl/mseq_sync_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mseq_sync_decoder
//  Description : Receives the serial m-sequence, acquires its absolute phase
//                by window lookup, verifies the phase over LOCK_CNT correct
//                predictions, then tracks it while tolerating up to MISS_MAX
//                consecutive mispredictions. All outputs are registered and
//                move only in the cycle after a bit_valid strobe (or reacq).
//  Revision    : 1.0 - initial release
//
//  Ports:
//    CLK_50MHZ  in  1    system clock
//    RST_N      in  1    asynchronous active-low reset
//    bit_in     in  1    serial bit, sampled when bit_valid=1
//    bit_valid  in  1    one-cycle bit strobe
//    reacq      in  1    drop lock and restart acquisition (wins over bit)
//    window     out DEG  last DEG received bits, newest in LSB
//    pos        out 8    sequence index of the newest received bit
//    pos_valid  out 1    pos meaningful (VERIFY or LOCKED)
//    locked     out 1    high in LOCKED only
//    err_cnt    out 8    saturating misprediction / illegal-window count
// ============================================================================
module mseq_sync_decoder #(
  parameter int DEG      = 5,
  parameter int LEN      = 31,
  parameter int LOCK_CNT = 8,
  parameter int MISS_MAX = 2
) (
  input  logic           CLK_50MHZ,
  input  logic           RST_N,
  input  logic           bit_in,
  input  logic           bit_valid,
  input  logic           reacq,
  output logic [DEG-1:0] window,
  output logic [7:0]     pos,
  output logic           pos_valid,
  output logic           locked,
  output logic [7:0]     err_cnt
);
  import mseq_pkg::*;

  localparam int FILL_W  = $clog2(DEG + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(MISS_MAX + 1);

  localparam logic [FILL_W-1:0]  c_FILL_LAST = FILL_W'(DEG - 1);
  localparam logic [FILL_W-1:0]  c_FILL_FULL = FILL_W'(DEG);
  localparam logic [MATCH_W-1:0] c_MATCH_END = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  c_MISS_END  = MISS_W'(MISS_MAX);
  localparam logic [7:0]         c_POS_LAST  = 8'(LEN - 1);

  mseq_state_e        state_q,     state_d;
  logic [DEG-1:0]     window_q,    window_d;
  logic [7:0]         pos_q,       pos_d;
  logic               pos_valid_q, pos_valid_d;
  logic               locked_q,    locked_d;
  logic [7:0]         err_cnt_q,   err_cnt_d;
  logic [FILL_W-1:0]  fill_q,      fill_d;
  logic [MATCH_W-1:0] match_q,     match_d;
  logic [MISS_W-1:0]  miss_q,      miss_d;

  logic [DEG-1:0] win_shift;
  logic [7:0]     lut_pos;
  logic           lut_valid;
  logic           bit_ok;
  logic [7:0]     pos_inc;
  logic [7:0]     err_inc;

  assign win_shift = {window_q[DEG-2:0], bit_in};

  // The lookup always sees the post-shift window; the prediction uses the
  // pre-shift window.
  mseq_pos_lut #(
    .DEG (DEG),
    .LEN (LEN)
  ) u_pos_lut (
    .window_i (win_shift),
    .pos_o    (lut_pos),
    .valid_o  (lut_valid)
  );

  assign bit_ok  = (bit_in == mseq_next(window_q));
  assign pos_inc = (pos_q == c_POS_LAST) ? 8'd0 : pos_q + 8'd1;
  assign err_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    pos_d       = pos_q;
    pos_valid_d = pos_valid_q;
    locked_d    = locked_q;
    err_cnt_d   = err_cnt_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;

    if (bit_valid) window_d = win_shift;

    if (reacq) begin
      state_d     = ACQ;
      pos_valid_d = 1'b0;
      locked_d    = 1'b0;
      err_cnt_d   = 8'd0;
      fill_d      = '0;
      match_d     = '0;
      miss_d      = '0;
    end else if (bit_valid) begin
      unique case (state_q)
        ACQ: begin
          if (fill_q < c_FILL_LAST) begin
            fill_d = fill_q + FILL_W'(1);
          end else begin
            // Window is full: keep the fill counter saturated so every
            // further bit retries the lookup until a legal window shows up.
            fill_d = c_FILL_FULL;
            if (lut_valid) begin
              pos_d       = lut_pos;
              pos_valid_d = 1'b1;
              match_d     = '0;
              state_d     = VERIFY;
            end else begin
              err_cnt_d = err_inc;
            end
          end
        end

        VERIFY: begin
          if (bit_ok) begin
            pos_d   = pos_inc;
            match_d = match_q + MATCH_W'(1);
            if (match_q == c_MATCH_END) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else begin
            err_cnt_d = err_inc;
            match_d   = '0;
            if (lut_valid) begin
              pos_d = lut_pos;
            end else begin
              state_d     = ACQ;
              pos_valid_d = 1'b0;
              fill_d      = c_FILL_FULL;
            end
          end
        end

        LOCKED: begin
          pos_d = pos_inc;
          if (bit_ok) begin
            miss_d = '0;
          end else begin
            err_cnt_d = err_inc;
            if (miss_q == c_MISS_END) begin
              // One miss beyond the tolerance: drop lock and arrange for the
              // very next bit to trigger a fresh lookup.
              state_d     = ACQ;
              locked_d    = 1'b0;
              pos_valid_d = 1'b0;
              fill_d      = c_FILL_LAST;
              miss_d      = '0;
              match_d     = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end

        default: begin
          state_d     = ACQ;
          pos_valid_d = 1'b0;
          locked_d    = 1'b0;
          fill_d      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ACQ;
      window_q    <= '0;
      pos_q       <= 8'd0;
      pos_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= 8'd0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
    end
  end

  assign window    = window_q;
  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign locked    = locked_q;
  assign err_cnt   = err_cnt_q;

endmodule : mseq_sync_decoder
`default_nettype wire
